// File: rtl/alu_pkg.sv
// ALU function-select map and sequencer state encoding shared by every ALU client.
package alu_pkg;

  // 16-bit ALU operations (bit 4 set selects the 16-bit datapath)
  localparam logic [4:0] FS_PASSA = 5'b10000;
  localparam logic [4:0] FS_PASSB = 5'b10001;
  localparam logic [4:0] FS_NOTA  = 5'b10010;
  localparam logic [4:0] FS_NEGA  = 5'b10011;
  localparam logic [4:0] FS_ADD   = 5'b10100;
  localparam logic [4:0] FS_ADC   = 5'b10101;
  localparam logic [4:0] FS_SUB   = 5'b10110;
  localparam logic [4:0] FS_SBC   = 5'b10111;
  localparam logic [4:0] FS_AND   = 5'b11000;
  localparam logic [4:0] FS_OR    = 5'b11001;
  localparam logic [4:0] FS_XOR   = 5'b11010;
  localparam logic [4:0] FS_LSL   = 5'b11011;
  localparam logic [4:0] FS_LSR   = 5'b11100;
  localparam logic [4:0] FS_ASR   = 5'b11101;
  localparam logic [4:0] FS_ROL   = 5'b11110;
  localparam logic [4:0] FS_ROR   = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the shared ALU for every add and shift.
// Produces the low WIDTH bits of OpA*OpB after a fixed 2*WIDTH+1 busy cycles.
module alu_mul_sequencer #(
  parameter int          WIDTH    = 16,
  parameter logic [4:0]  FS_ADD   = alu_pkg::FS_ADD,
  parameter logic [4:0]  FS_LSL   = alu_pkg::FS_LSL,
  parameter logic [4:0]  FS_PASSA = alu_pkg::FS_PASSA
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             AluReq,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [4:0]       AluFunSel,
  output logic             AluWF,
  input  logic [WIDTH-1:0] AluOut
);
  import alu_pkg::*;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  seq_state_e       state, state_nxt;
  logic [WIDTH-1:0] m, q, acc;
  logic [CW-1:0]    cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_IDLE;
      m      <= '0;
      q      <= '0;
      acc    <= '0;
      cnt    <= '0;
      Result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (Start) begin
          m   <= OpA;
          q   <= OpB;
          acc <= '0;
          cnt <= '0;
        end
        S_ADD: if (q[0]) acc <= AluOut;
        S_SHIFT: begin
          m   <= AluOut;
          q   <= q >> 1;
          cnt <= cnt + 1'b1;
          // acc is final here, so Result is already valid while Done is high
          if (cnt == CNT_LAST) Result <= acc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    AluFunSel = FS_PASSA;
    AluA      = '0;
    AluB      = '0;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_ADD;
      S_ADD: begin
        AluFunSel = FS_ADD;
        AluA      = acc;
        AluB      = m;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        AluFunSel = FS_LSL;
        AluA      = m;
        state_nxt = (cnt == CNT_LAST) ? S_DONE : S_ADD;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign Busy   = (state != S_IDLE);
  assign Done   = (state == S_DONE);
  assign AluReq = Busy;
  assign AluWF  = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed + random bench for alu_mul_sequencer with a bench-side ALU and result scoreboard.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] OpA = '0, OpB = '0;
  logic        Busy, Done, AluReq, AluWF;
  logic [15:0] Result, AluA, AluB, AluOut;
  logic [4:0]  AluFunSel;

  int errors = 0;
  int checks = 0;

  alu_mul_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .Result(Result), .AluReq(AluReq),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
    .AluOut(AluOut)
  );

  always #5 Clock = ~Clock;

  // Reference ALU standing in for the shared datapath unit
  always_comb begin
    case (AluFunSel)
      FS_ADD:   AluOut = AluA + AluB;
      FS_LSL:   AluOut = AluA << 1;
      FS_PASSA: AluOut = AluA;
      default:  AluOut = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard and cycle-phase model: ph 0 idle, odd = ADD, even 2..32 = SHIFT, 33 = DONE
  logic [15:0] exp_q[$];
  int          ph = 0;
  int          done_cnt = 0;
  logic [15:0] m_m, q_m, acc_m;

  always @(negedge Clock) begin
    if (Done) done_cnt++;
    if (Reset) begin
      ph = 0;
      exp_q.delete();
    end else begin
      chk("alu_wf", AluWF, 1'b0);
      chk("aluReq_eq_busy", AluReq, Busy);
      if (ph == 0) begin
        chk("idle_busy", Busy, 1'b0);
        chk("idle_done", Done, 1'b0);
        chk("idle_fs", AluFunSel, FS_PASSA);
        chk("idle_ab", {AluA, AluB}, 32'h0);
        if (Start) begin
          m_m = OpA; q_m = OpB; acc_m = '0;
          exp_q.push_back(16'(32'(OpA) * 32'(OpB)));
          ph = 1;
        end
      end else if (ph == 33) begin
        chk("done_pulse", Done, 1'b1);
        chk("done_busy", Busy, 1'b1);
        chk("done_fs", AluFunSel, FS_PASSA);
        chk("done_ab", {AluA, AluB}, 32'h0);
        if (exp_q.size() == 0) chk("sb_empty_at_done", 1'b1, 1'b0);
        else chk("result", Result, exp_q.pop_front());
        ph = 0;
      end else begin
        chk("op_busy", Busy, 1'b1);
        chk("op_done", Done, 1'b0);
        if (ph % 2 == 1) begin
          chk("add_fs", AluFunSel, FS_ADD);
          chk("add_a_acc", AluA, acc_m);
          chk("add_b_m", AluB, m_m);
          if (q_m[0]) acc_m = acc_m + m_m;
        end else begin
          chk("shift_fs", AluFunSel, FS_LSL);
          chk("shift_a_m", AluA, m_m);
          m_m = m_m << 1;
          q_m = q_m >> 1;
        end
        ph++;
      end
    end
  end

  // Called just after a posedge; leaves Start low shortly after the accepting edge
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    #2;
    OpA = a; OpB = b; Start = 1'b1;
    @(posedge Clock);
    #2;
    Start = 1'b0;
    OpA = ~a; OpB = ~b;
  endtask

  task automatic wait_done();
    int n = 0;
    while (ph != 0 && n < 40) begin
      @(posedge Clock);
      n++;
    end
    if (ph != 0) chk("done_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge Clock);
    #2 Reset = 1'b0;
    @(negedge Clock);
    chk("rst_result", Result, 16'h0000);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_fs", AluFunSel, FS_PASSA);
    @(posedge Clock);

    // Basic, truncation and zero-operand cases
    start_op(16'd3, 16'd5);          wait_done();
    chk("r_3x5", Result, 16'h000F);
    start_op(16'hFFFF, 16'hFFFF);    wait_done();
    start_op(16'h0100, 16'h0100);    wait_done();
    start_op(16'h1234, 16'h0000);    wait_done();
    start_op(16'h0000, 16'hABCD);    wait_done();
    chk("r_zero", Result, 16'h0000);

    // Start during busy is ignored; back-to-back start right after DONE
    start_op(16'd3, 16'd5);
    repeat (8) @(posedge Clock);
    #2 OpA = 16'd7; OpB = 16'd7; Start = 1'b1;
    @(posedge Clock);
    #2 Start = 1'b0;
    wait_done();
    chk("r_ignored_start", Result, 16'h000F);
    start_op(16'd7, 16'd7);          wait_done();
    chk("r_b2b", Result, 16'h0031);

    // Reset mid-operation aborts with no Done pulse
    start_op(16'h00FF, 16'h0002);
    repeat (10) @(posedge Clock);
    d0 = done_cnt;
    #2 Reset = 1'b1;
    @(posedge Clock);
    #2 Reset = 1'b0;
    @(negedge Clock);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_result", Result, 16'h0000);
    chk("abort_fs", AluFunSel, FS_PASSA);
    chk("abort_ab", {AluA, AluB}, 32'h0);
    repeat (40) @(posedge Clock);
    chk("abort_no_done", done_cnt, d0);
    start_op(16'h00FF, 16'h0002);    wait_done();
    chk("r_after_reset", Result, 16'h01FE);

    // Random operands, including back-to-back issue
    for (int i = 0; i < 1000; i++) begin
      start_op(16'($urandom), 16'($urandom));
      wait_done();
    end

    repeat (2) @(posedge Clock);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
